result_display_driver: RTL and testbench

Downstream consumer of the RISC-V processor's 16-bit `result` output. It drives a 4-digit, active-low, multiplexed 7-segment display on the FPGA board. It keeps a shadow copy of `result`, counts how many times the value changes, and scans the four hex digits with a programmable refresh divider. Leading-zero blanking and a hold/freeze mode are included.

---
 rtl/result_display_pkg.sv | 30 +++
 rtl/hex_to_7seg.sv | 18 +
 rtl/result_display_driver.sv | 162 ++++++++++++++++
 tb/tb_result_display_driver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/result_display_pkg.sv
// ---------------------------------------------------------------------------
// result_display_pkg
// Shared constants and types for the 4-digit multiplexed 7-segment display
// driver that sits behind the processor's 16-bit result bus.
//   NUM_DIGITS   : number of scanned digits on the board
//   SEG_BLANK    : active-low segment pattern with every segment off
//   SEG_TABLE    : hex nibble -> active-low segments, bit order {g,f,e,d,c,b,a}
//   scan_state_e : which digit the scanner is currently driving
// ---------------------------------------------------------------------------
package result_display_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } scan_state_e;

endpackage

// File: rtl/hex_to_7seg.sv
// ---------------------------------------------------------------------------
// hex_to_7seg
// Purely combinational hex digit decoder for an active-low 7-segment display.
//   nibble : 4-bit hex value to show
//   seg_n  : active-low segment drive, bit order {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex_to_7seg
   import result_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   // Straight table lookup; the table lives in the package so the bench and
   // any other display block share one definition of the glyphs.
   assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/result_display_driver.sv
// ---------------------------------------------------------------------------
// result_display_driver
// Shadows the processor result bus, counts how often it changes and scans the
// four hex digits onto a multiplexed, active-low 7-segment display.
//   clk          : system clock
//   reset        : asynchronous reset, active low
//   result       : processor result bus
//   hold         : 1 = freeze the shown value (scanning continues)
//   seg_n        : active-low segments {g,f,e,d,c,b,a}
//   dp_n         : active-low decimal point, lit on digit 0 while frozen
//   an_n         : active-low digit anodes, bit k = digit k
//   shown_value  : value currently on the display
//   update_count : number of captures since reset, wraps modulo 256
// ---------------------------------------------------------------------------
module result_display_driver
   import result_display_pkg::*;
#(
   parameter int REFRESH_DIV   = 50000,
   parameter bit BLANK_LEADING = 1'b1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] result,
   input  logic        hold,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [3:0]  an_n,
   output logic [15:0] shown_value,
   output logic [7:0]  update_count
);

   // A divider of 1 would give a zero-width counter, so keep at least one bit.
   localparam int              PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

   logic [15:0]           shown_q, shown_d;
   logic [7:0]            count_q, count_d;
   logic [PRE_W-1:0]      presc_q, presc_d;
   logic                  terminal;
   scan_state_e           state_q, state_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [3:0]            nibble;
   logic [6:0]            nibble_seg;
   logic                  blank;

   // Capture: only a genuinely different value counts as an update, and hold
   // freezes both the shadow copy and the counter.
   always_comb begin
      shown_d = shown_q;
      count_d = count_q;
      if (!hold && (result != shown_q)) begin
         shown_d = result;
         count_d = count_q + 8'd1;
      end
   end

   // Prescaler: free-running 0..REFRESH_DIV-1, the wrap is the scan tick.
   always_comb begin
      terminal = (presc_q == PRE_LAST);
      presc_d  = terminal ? '0 : presc_q + PRE_W'(1);
   end

   // Scan FSM next state: one digit per prescaler wrap, hold has no effect.
   always_comb begin
      state_d = state_q;
      if (terminal) begin
         case (state_q)
            DIG0:    state_d = DIG1;
            DIG1:    state_d = DIG2;
            DIG2:    state_d = DIG3;
            DIG3:    state_d = DIG0;
            default: state_d = DIG0;
         endcase
      end
   end

   // Output decode from the current state and current shown value. A digit
   // above 0 is blanked when it and every more significant nibble is zero.
   always_comb begin
      nibble = shown_q[3:0];
      an_d   = 4'b1110;
      blank  = 1'b0;
      dp_d   = 1'b1;
      case (state_q)
         DIG0: begin
            nibble = shown_q[3:0];
            an_d   = 4'b1110;
            dp_d   = !hold;
         end
         DIG1: begin
            nibble = shown_q[7:4];
            an_d   = 4'b1101;
            blank  = BLANK_LEADING && (shown_q[15:4] == 12'h000);
         end
         DIG2: begin
            nibble = shown_q[11:8];
            an_d   = 4'b1011;
            blank  = BLANK_LEADING && (shown_q[15:8] == 8'h00);
         end
         DIG3: begin
            nibble = shown_q[15:12];
            an_d   = 4'b0111;
            blank  = BLANK_LEADING && (shown_q[15:12] == 4'h0);
         end
         default: begin
            nibble = shown_q[3:0];
            an_d   = 4'b1110;
         end
      endcase
      seg_d = blank ? SEG_BLANK : nibble_seg;
   end

   hex_to_7seg u_hex_to_7seg (
      .nibble (nibble),
      .seg_n  (nibble_seg)
   );

   // Shadow value and update counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shown_q <= 16'h0000;
         count_q <= 8'h00;
      end else begin
         shown_q <= shown_d;
         count_q <= count_d;
      end
   end

   // Prescaler and scan state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
         state_q <= DIG0;
      end else begin
         presc_q <= presc_d;
         state_q <= state_d;
      end
   end

   // Registered display drive; everything dark while in reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an_q  <= 4'b1111;
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign seg_n        = seg_q;
   assign dp_n         = dp_q;
   assign an_n         = an_q;
   assign shown_value  = shown_q;
   assign update_count = count_q;

endmodule

// File: tb/tb_result_display_driver.sv
// ---------------------------------------------------------------------------
// tb_result_display_driver
// Directed bench for result_display_driver with REFRESH_DIV = 4 and leading
// zero blanking on. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_result_display_driver;

   logic        clk;
   logic        reset;
   logic [15:0] result;
   logic        hold;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  an_n;
   logic [15:0] shown_value;
   logic [7:0]  update_count;

   int vectors;
   int miscompares;

   result_display_driver #(
      .REFRESH_DIV   (4),
      .BLANK_LEADING (1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .result       (result),
      .hold         (hold),
      .seg_n        (seg_n),
      .dp_n         (dp_n),
      .an_n         (an_n),
      .shown_value  (shown_value),
      .update_count (update_count)
   );

   // 10 time-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison point.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkDisplay(input string tag, input logic [3:0] exp_an,
                               input logic [6:0] exp_seg, input logic exp_dp);
      checkOutput({tag, " an_n"}, {12'h000, an_n}, {12'h000, exp_an});
      checkOutput({tag, " seg_n"}, {9'h000, seg_n}, {9'h000, exp_seg});
      checkOutput({tag, " dp_n"}, {15'h0000, dp_n}, {15'h0000, exp_dp});
   endtask

   task automatic checkValue(input string tag, input logic [15:0] exp_shown,
                             input logic [7:0] exp_count);
      checkOutput({tag, " shown_value"}, shown_value, exp_shown);
      checkOutput({tag, " update_count"}, {8'h00, update_count}, {8'h00, exp_count});
   endtask

   // Advance n clock cycles, landing on a falling edge.
   task automatic applyStimulus(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      hold        = 1'b0;
      result      = 16'h1234;
      reset       = 1'b1;

      // 1: reset values, then capture and a full scan of 1234
      #2 reset = 1'b0;
      #1;
      checkDisplay("t1 in reset", 4'b1111, 7'h7F, 1'b1);
      checkValue("t1 in reset", 16'h0000, 8'd0);
      applyStimulus(2);
      checkDisplay("t1 reset held", 4'b1111, 7'h7F, 1'b1);
      reset = 1'b1;
      applyStimulus(1);
      checkValue("t1 first capture", 16'h1234, 8'd1);
      checkDisplay("t1 first edge lag", 4'b1110, 7'h40, 1'b1);
      applyStimulus(1);
      checkDisplay("t1 digit0", 4'b1110, 7'h19, 1'b1);
      applyStimulus(3);
      checkDisplay("t1 digit1", 4'b1101, 7'h30, 1'b1);
      applyStimulus(4);
      checkDisplay("t1 digit2", 4'b1011, 7'h24, 1'b1);
      applyStimulus(4);
      checkDisplay("t1 digit3", 4'b0111, 7'h79, 1'b1);
      applyStimulus(4);
      checkDisplay("t1 wrap digit0", 4'b1110, 7'h19, 1'b1);

      // 2: 0005 blanks the three upper digits
      result = 16'h0005;
      applyStimulus(1);
      checkValue("t2 capture", 16'h0005, 8'd2);
      checkDisplay("t2 old value", 4'b1110, 7'h19, 1'b1);
      applyStimulus(1);
      checkDisplay("t2 digit0", 4'b1110, 7'h12, 1'b1);
      applyStimulus(2);
      checkDisplay("t2 digit1 blank", 4'b1101, 7'h7F, 1'b1);
      applyStimulus(4);
      checkDisplay("t2 digit2 blank", 4'b1011, 7'h7F, 1'b1);
      applyStimulus(4);
      checkDisplay("t2 digit3 blank", 4'b0111, 7'h7F, 1'b1);

      // 3: zero after reset is not a capture, digit 0 still shows "0"
      result = 16'h0000;
      reset  = 1'b0;
      #1;
      checkDisplay("t3 async reset", 4'b1111, 7'h7F, 1'b1);
      checkValue("t3 async reset", 16'h0000, 8'd0);
      applyStimulus(1);
      reset = 1'b1;
      applyStimulus(1);
      checkValue("t3 no capture", 16'h0000, 8'd0);
      checkDisplay("t3 digit0 zero", 4'b1110, 7'h40, 1'b1);
      applyStimulus(1);
      checkValue("t3 still zero", 16'h0000, 8'd0);
      applyStimulus(4);
      checkDisplay("t3 digit1 blank", 4'b1101, 7'h7F, 1'b1);

      // 4: hold freezes ABCD and lights dp on digit 0 only
      result = 16'hABCD;
      applyStimulus(1);
      checkValue("t4 capture ABCD", 16'hABCD, 8'd1);
      hold   = 1'b1;
      result = 16'h1111;
      applyStimulus(1);
      checkValue("t4 held", 16'hABCD, 8'd1);
      checkDisplay("t4 held digit1", 4'b1101, 7'h46, 1'b1);
      applyStimulus(5);
      checkDisplay("t4 held digit3", 4'b0111, 7'h08, 1'b1);
      applyStimulus(4);
      checkDisplay("t4 held digit0 dp", 4'b1110, 7'h21, 1'b0);
      checkValue("t4 still held", 16'hABCD, 8'd1);
      hold = 1'b0;
      applyStimulus(1);
      checkValue("t4 release capture", 16'h1111, 8'd2);
      checkDisplay("t4 release dp off", 4'b1110, 7'h21, 1'b1);
      applyStimulus(1);
      checkDisplay("t4 new digit0", 4'b1110, 7'h79, 1'b1);

      // 5: 256 alternating captures wrap the counter back to its start
      for (int i = 0; i < 256; i++) begin
         result = (i % 2 == 0) ? 16'h0001 : 16'h0002;
         applyStimulus(1);
         if (i == 252) checkValue("t5 count 255", 16'h0001, 8'd255);
         if (i == 253) checkValue("t5 count wrap", 16'h0002, 8'd0);
      end
      checkValue("t5 final", 16'h0002, 8'd2);
      applyStimulus(1);
      checkValue("t5 equal no count", 16'h0002, 8'd2);

      // 6: reset during digit 2 blanks at once, scan restarts at digit 0
      result = 16'h0F00;
      reset  = 1'b0;
      applyStimulus(1);
      reset = 1'b1;
      applyStimulus(10);
      checkDisplay("t6 in digit2", 4'b1011, 7'h0E, 1'b1);
      #2 reset = 1'b0;
      #1;
      checkDisplay("t6 mid-scan reset", 4'b1111, 7'h7F, 1'b1);
      checkValue("t6 mid-scan reset", 16'h0000, 8'd0);
      applyStimulus(1);
      reset = 1'b1;
      applyStimulus(1);
      checkDisplay("t6 restart digit0", 4'b1110, 7'h40, 1'b1);
      checkValue("t6 recapture", 16'h0F00, 8'd1);
      applyStimulus(4);
      checkDisplay("t6 restart digit1", 4'b1101, 7'h40, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
